// File: rtl/port_lookup_sched.sv
// -----------------------------------------------------------------------------
// port_lookup_sched
//
// Scheduler and configuration controller for the shared port-hash lookup
// datapath. One lookup pipeline is time-multiplexed between a source-port and
// a destination-port requester with round-robin arbitration. Every issued
// lookup carries a one-bit tag through a LAT-deep shift register so the result
// returns to the requester that issued it. Runtime table writes are serialised:
// the pipeline is drained first, so no lookup ever sees a half-written table.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   src_req/src_key/src_gnt        source requester (gnt is combinational)
//   dst_req/dst_key/dst_gnt        destination requester (gnt is combinational)
//   src_rvalid/src_index           source result pulse and index
//   dst_rvalid/dst_index           destination result pulse and index
//   cfg_req/cfg_sel/cfg_addr/
//   cfg_data/cfg_ack               table write request, ack pulses on write
//   lk_valid/lk_key                registered lookup issue to the datapath
//   lk_index                       datapath result, LAT cycles after lk_valid
//   tbl_we/tbl_sel/tbl_addr/
//   tbl_data                       registered table write port
//   busy                           lookups in flight or a write in progress
// -----------------------------------------------------------------------------
module port_lookup_sched #(
  parameter int IW  = 10,
  parameter int AW  = 10,
  parameter int LAT = 3
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          src_req,
  input  logic [15:0]   src_key,
  output logic          src_gnt,
  input  logic          dst_req,
  input  logic [15:0]   dst_key,
  output logic          dst_gnt,

  output logic          src_rvalid,
  output logic [IW-1:0] src_index,
  output logic          dst_rvalid,
  output logic [IW-1:0] dst_index,

  input  logic          cfg_req,
  input  logic [1:0]    cfg_sel,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_data,
  output logic          cfg_ack,

  output logic          lk_valid,
  output logic [15:0]   lk_key,
  input  logic [IW-1:0] lk_index,

  output logic          tbl_we,
  output logic [1:0]    tbl_sel,
  output logic [AW-1:0] tbl_addr,
  output logic [15:0]   tbl_data,

  output logic          busy
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_WRITE
  } state_t;

  localparam logic [1:0] SEL_RESERVED = 2'd3;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_prev_write;   // previous cycle was WRITE
  logic            r_rr;           // round-robin pointer: 0 = src, 1 = dst

  logic            r_lk_valid;
  logic            r_lk_tag;       // tag of the lookup currently on lk_valid
  logic [15:0]     r_lk_key;

  // Tag pipe: stage 0 follows lk_valid by one cycle, so the last stage lines
  // up with lk_index, which arrives LAT cycles after lk_valid.
  logic [LAT-1:0]  r_pipe_v;
  logic [LAT-1:0]  r_pipe_t;

  logic            r_src_rvalid;
  logic [IW-1:0]   r_src_index;
  logic            r_dst_rvalid;
  logic [IW-1:0]   r_dst_index;

  logic            r_tbl_we;
  logic [1:0]      r_tbl_sel;
  logic [AW-1:0]   r_tbl_addr;
  logic [15:0]     r_tbl_data;

  logic            w_src_gnt;
  logic            w_dst_gnt;
  logic            w_pipe_busy;
  logic            w_grant_ok;
  logic            w_do_write;

  assign w_pipe_busy = r_lk_valid | (|r_pipe_v);

  // Lookups are blocked while a write is pending, except in the cycle right
  // after a write, which always gives lookups a chance so back-to-back writes
  // cannot starve the requesters. Reset also masks grants so nothing is
  // issued into a pipe that is being cleared.
  assign w_grant_ok  = !rst && (!cfg_req || r_prev_write);

  // ---------------------------------------------------------------------------
  // Next-state and grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    w_next_state = r_state;
    w_src_gnt    = 1'b0;
    w_dst_gnt    = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_grant_ok) begin
          if (src_req && (!dst_req || !r_rr)) begin
            w_src_gnt = 1'b1;
          end else if (dst_req) begin
            w_dst_gnt = 1'b1;
          end
        end
        if (cfg_req && !r_prev_write) begin
          w_next_state = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!w_pipe_busy) begin
          w_next_state = ST_WRITE;
        end
      end

      ST_WRITE: begin
        w_next_state = ST_RUN;
      end

      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // The table write strobe is registered, so it is loaded on the edge that
  // enters WRITE and is visible in the same cycle as cfg_ack.
  assign w_do_write = (w_next_state == ST_WRITE);

  // ---------------------------------------------------------------------------
  // State, arbitration pointer and issue registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= ST_RUN;
      r_prev_write <= 1'b0;
      r_rr         <= 1'b0;
      r_lk_valid   <= 1'b0;
      r_lk_tag     <= 1'b0;
      r_lk_key     <= '0;
    end else begin
      r_state      <= w_next_state;
      r_prev_write <= (r_state == ST_WRITE);
      r_lk_valid   <= w_src_gnt | w_dst_gnt;
      r_lk_tag     <= w_dst_gnt;
      if (w_src_gnt) begin
        r_lk_key <= src_key;
        r_rr     <= 1'b1;
      end else if (w_dst_gnt) begin
        r_lk_key <= dst_key;
        r_rr     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe and result return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the tag valid bits are reset so in-flight lookups are discarded;
    // without it a stale tag could produce a spurious rvalid after reset.
    if (rst) begin
      r_pipe_v <= '0;
      r_pipe_t <= '0;
    end else begin
      r_pipe_v[0] <= r_lk_valid;
      r_pipe_t[0] <= r_lk_tag;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_t[i] <= r_pipe_t[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_rvalid <= 1'b0;
      r_src_index  <= '0;
      r_dst_rvalid <= 1'b0;
      r_dst_index  <= '0;
    end else begin
      r_src_rvalid <= r_pipe_v[LAT-1] && !r_pipe_t[LAT-1];
      r_dst_rvalid <= r_pipe_v[LAT-1] &&  r_pipe_t[LAT-1];
      if (r_pipe_v[LAT-1] && !r_pipe_t[LAT-1]) begin
        r_src_index <= lk_index;
      end
      if (r_pipe_v[LAT-1] && r_pipe_t[LAT-1]) begin
        r_dst_index <= lk_index;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tbl_we   <= 1'b0;
      r_tbl_sel  <= '0;
      r_tbl_addr <= '0;
      r_tbl_data <= '0;
    end else begin
      r_tbl_we <= w_do_write && (cfg_sel != SEL_RESERVED);
      // Reserved selects are acknowledged but leave the write port untouched.
      if (w_do_write && (cfg_sel != SEL_RESERVED)) begin
        r_tbl_sel  <= cfg_sel;
        r_tbl_addr <= cfg_addr;
        r_tbl_data <= cfg_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign src_gnt    = w_src_gnt;
  assign dst_gnt    = w_dst_gnt;
  assign src_rvalid = r_src_rvalid;
  assign src_index  = r_src_index;
  assign dst_rvalid = r_dst_rvalid;
  assign dst_index  = r_dst_index;
  assign cfg_ack    = (r_state == ST_WRITE);
  assign lk_valid   = r_lk_valid;
  assign lk_key     = r_lk_key;
  assign tbl_we     = r_tbl_we;
  assign tbl_sel    = r_tbl_sel;
  assign tbl_addr   = r_tbl_addr;
  assign tbl_data   = r_tbl_data;
  assign busy       = w_pipe_busy | (r_state != ST_RUN);

endmodule

// File: tb/tb_port_lookup_sched.sv
// -----------------------------------------------------------------------------
// tb_port_lookup_sched
//
// Directed bench for port_lookup_sched. A stub datapath returns key % 77 LAT
// cycles after lk_valid. A cycle-indexed event model predicts grants, issues,
// returns, acks and busy from the arbitration and drain rules; one compare
// process checks the DUT against it every cycle, and the directed sequences
// pin a few hand-computed values.
// -----------------------------------------------------------------------------
module tb_port_lookup_sched;

  localparam int IW   = 10;
  localparam int AW   = 10;
  localparam int LAT  = 3;
  localparam int MAXC = 4096;

  logic          clk;
  logic          rst;
  logic          src_req, dst_req;
  logic [15:0]   src_key, dst_key;
  logic          src_gnt, dst_gnt;
  logic          src_rvalid, dst_rvalid;
  logic [IW-1:0] src_index, dst_index;
  logic          cfg_req;
  logic [1:0]    cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_data;
  logic          cfg_ack;
  logic          lk_valid;
  logic [15:0]   lk_key;
  logic [IW-1:0] lk_index;
  logic          tbl_we;
  logic [1:0]    tbl_sel;
  logic [AW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  port_lookup_sched #(.IW(IW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_key(src_key), .src_gnt(src_gnt),
    .dst_req(dst_req), .dst_key(dst_key), .dst_gnt(dst_gnt),
    .src_rvalid(src_rvalid), .src_index(src_index),
    .dst_rvalid(dst_rvalid), .dst_index(dst_index),
    .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .lk_valid(lk_valid), .lk_key(lk_key), .lk_index(lk_index),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] lookup_fn(input logic [15:0] k);
    return IW'(k % 16'd77);
  endfunction

  // Stub datapath: fixed LAT-cycle delay; drives all-ones when idle so a
  // misaligned sample is visible.
  logic        stub_v [LAT];
  logic [15:0] stub_k [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stub_v[i] <= 1'b0;
    end else begin
      stub_v[0] <= lk_valid;
      stub_k[0] <= lk_key;
      for (int i = 1; i < LAT; i++) begin
        stub_v[i] <= stub_v[i-1];
        stub_k[i] <= stub_k[i-1];
      end
    end
  end
  assign lk_index = stub_v[LAT-1] ? lookup_fn(stub_k[LAT-1]) : '1;

  // ---------------------------------------------------------------------------
  // Event model: expected events stored by the cycle they must appear in.
  // ---------------------------------------------------------------------------
  logic          e_lkv  [MAXC];
  logic [15:0]   e_lkk  [MAXC];
  logic          e_srv  [MAXC];
  logic          e_drv  [MAXC];
  logic [IW-1:0] e_sidx [MAXC];
  logic [IW-1:0] e_didx [MAXC];
  int            e_infl [MAXC];

  logic m_dst_first;   // dst has priority on the next contested cycle
  logic m_prev_ack;    // previous cycle acknowledged a write
  logic m_wr_pending;
  int   m_ack_cyc;
  int   m_last_rv;

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) begin
      e_lkv[i] = 1'b0; e_lkk[i] = '0; e_srv[i] = 1'b0; e_drv[i] = 1'b0;
      e_sidx[i] = '0;  e_didx[i] = '0; e_infl[i] = 0;
    end
    m_dst_first  = 1'b0;
    m_prev_ack   = 1'b0;
    m_wr_pending = 1'b0;
    m_ack_cyc    = 0;
    m_last_rv    = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_clear();
    end else begin
      int   c;
      logic exp_sg, exp_dg, exp_busy;
      c = cyc;
      exp_sg = 1'b0;
      exp_dg = 1'b0;
      if (m_wr_pending && c == m_ack_cyc) begin
        // Write cycle
        check("gnt in write", {src_gnt, dst_gnt}, 2'b00);
        check("cfg_ack", cfg_ack, 1'b1);
        check("tbl_we", tbl_we, cfg_sel != 2'd3);
        if (cfg_sel != 2'd3) begin
          check("tbl_sel", tbl_sel, cfg_sel);
          check("tbl_addr", tbl_addr, cfg_addr);
          check("tbl_data", tbl_data, cfg_data);
        end
        exp_busy     = 1'b1;
        m_wr_pending = 1'b0;
        m_prev_ack   = 1'b1;
      end else if (m_wr_pending) begin
        // Waiting for in-flight results before writing
        check("gnt in drain", {src_gnt, dst_gnt}, 2'b00);
        check("cfg_ack idle", cfg_ack, 1'b0);
        check("tbl_we idle", tbl_we, 1'b0);
        exp_busy   = 1'b1;
        m_prev_ack = 1'b0;
      end else begin
        if (!cfg_req || m_prev_ack) begin
          if (src_req && (!dst_req || !m_dst_first)) exp_sg = 1'b1;
          else if (dst_req)                          exp_dg = 1'b1;
        end
        check("src_gnt", src_gnt, exp_sg);
        check("dst_gnt", dst_gnt, exp_dg);
        check("cfg_ack idle", cfg_ack, 1'b0);
        check("tbl_we idle", tbl_we, 1'b0);
        if (exp_sg || exp_dg) begin
          logic [15:0] k;
          int r;
          k = exp_sg ? src_key : dst_key;
          r = c + 2 + LAT;
          m_dst_first = exp_sg;
          e_lkv[c+1]  = 1'b1;
          e_lkk[c+1]  = k;
          if (exp_sg) begin e_srv[r] = 1'b1; e_sidx[r] = lookup_fn(k); end
          else        begin e_drv[r] = 1'b1; e_didx[r] = lookup_fn(k); end
          for (int k2 = c + 1; k2 < r; k2++) e_infl[k2]++;
          m_last_rv = r;
        end
        exp_busy = (e_infl[c] > 0);
        if (cfg_req && !m_prev_ack) begin
          m_wr_pending = 1'b1;
          m_ack_cyc    = (c + 2 > m_last_rv + 1) ? c + 2 : m_last_rv + 1;
        end
        m_prev_ack = 1'b0;
      end
      check("busy", busy, exp_busy);
      check("lk_valid", lk_valid, e_lkv[c]);
      if (e_lkv[c]) check("lk_key", lk_key, e_lkk[c]);
      check("src_rvalid", src_rvalid, e_srv[c]);
      if (e_srv[c]) check("src_index", src_index, e_sidx[c]);
      check("dst_rvalid", dst_rvalid, e_drv[c]);
      if (e_drv[c]) check("dst_index", dst_index, e_didx[c]);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int ack_i, last_rv, ngnt;
    rst = 1'b1;
    src_req = 1'b0; src_key = '0;
    dst_req = 1'b0; dst_key = '0;
    cfg_req = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset lk_valid", lk_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset indices", {src_index, dst_index}, '0);
    idle(2);

    // Single source lookup: key 0x0050 -> index 3
    src_req = 1'b1; src_key = 16'h0050;
    @(negedge clk);
    check("t1 src_gnt", src_gnt, 1'b1);
    step();
    src_req = 1'b0; src_key = 16'hDEAD;
    @(negedge clk);
    check("t1 lk_valid", lk_valid, 1'b1);
    check("t1 lk_key", lk_key, 16'h0050);
    repeat (3) @(negedge clk);
    check("t1 rvalid early", src_rvalid, 1'b0);
    @(negedge clk);
    check("t1 src_rvalid", src_rvalid, 1'b1);
    check("t1 src_index", src_index, 10'd3);
    idle(4);

    // Both requesters for 6 cycles; rr points at dst after the src grant
    for (int i = 0; i < 6; i++) begin
      src_req = 1'b1; src_key = 16'h1000 + 16'(i);
      dst_req = 1'b1; dst_key = 16'h2000 + 16'(i * 7);
      @(negedge clk);
      if (i == 0) check("t3 first dst", dst_gnt, 1'b1);
      if (i == 1) check("t3 then src", src_gnt, 1'b1);
      step();
    end
    src_req = 1'b0; dst_req = 1'b0;
    idle(10);

    // Write with two lookups in flight
    src_req = 1'b1; src_key = 16'h0111;
    step();
    src_key = 16'h0222;
    step();
    src_req = 1'b0;
    dst_req = 1'b1; dst_key = 16'h0333;
    cfg_req = 1'b1; cfg_sel = 2'd2; cfg_addr = 10'd5; cfg_data = 16'h01BB;
    ack_i = -1; last_rv = -1; ngnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (src_gnt || dst_gnt) ngnt++;
      if (src_rvalid) last_rv = i;
      if (cfg_ack) begin ack_i = i; break; end
    end
    check("t4 ack latency", ack_i, 5);
    check("t4 last rvalid", last_rv, 4);
    check("t4 no grants", ngnt, 0);
    check("t4 tbl_we", tbl_we, 1'b1);
    check("t4 tbl fields", {tbl_sel, tbl_addr, tbl_data}, {2'd2, 10'd5, 16'h01BB});
    step();
    cfg_req = 1'b0;
    @(negedge clk);
    check("t4 post-write grant", dst_gnt, 1'b1);
    step();
    dst_req = 1'b0;
    idle(10);

    // Reserved select from an idle pipe
    cfg_req = 1'b1; cfg_sel = 2'd3; cfg_addr = 10'd7; cfg_data = 16'hBEEF;
    ack_i = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_ack) begin ack_i = i; break; end
    end
    check("t5 ack latency", ack_i, 2);
    check("t5 no tbl_we", tbl_we, 1'b0);
    step();
    cfg_req = 1'b0;
    idle(6);

    // Back-to-back writes with dst requesting
    dst_req = 1'b1; dst_key = 16'h0444;
    cfg_req = 1'b1; cfg_sel = 2'd0; cfg_addr = 10'd1; cfg_data = 16'h1111;
    ack_i = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_ack) begin ack_i = i; break; end
    end
    check("t6 first ack", ack_i, 2);
    step();
    cfg_sel = 2'd1; cfg_addr = 10'd2; cfg_data = 16'h2222;
    ack_i = -1; ngnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dst_gnt) ngnt++;
      if (cfg_ack) begin ack_i = i; break; end
    end
    check("t6 grants between", ngnt, 1);
    check("t6 second ack", ack_i, 6);
    step();
    cfg_req = 1'b0; dst_req = 1'b0;
    idle(6);

    // Reset with two lookups in flight
    src_req = 1'b1; src_key = 16'h0555;
    dst_req = 1'b1; dst_key = 16'h0666;
    step();
    step();
    src_req = 1'b0; dst_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t7 outputs cleared",
          {lk_valid, src_rvalid, dst_rvalid, cfg_ack, tbl_we, busy},  '0);
    check("t7 data cleared", {lk_key, src_index, dst_index}, '0);
    check("t7 tbl cleared", {tbl_sel, tbl_addr, tbl_data}, '0);
    ngnt = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (src_rvalid || dst_rvalid) ngnt++;
    end
    check("t7 no rvalid", ngnt, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
